// File: rtl/ysyx_23060240_idu_pipe_if.sv
// Decode-stage bus: the IFU-facing handshake (in_*), the redirect flush,
// and the registered decode bundle handed to the EXU (out_*, alu_*, flags).
//   master : environment side (drives instruction, flush, out_ready)
//   slave  : decode stage side (drives in_ready and the decoded bundle)
interface ysyx_23060240_idu_pipe_if #(
  parameter int XLEN       = 32,
  parameter int ALU_FUNC_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [XLEN-1:0]       in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [4:0]            out_rs1;
  logic [4:0]            out_rs2;
  logic [4:0]            out_rd;
  logic [XLEN-1:0]       out_imm;
  logic [ALU_FUNC_W-1:0] alu_func;
  logic                  alu_a_sel;
  logic                  alu_b_sel;
  logic                  w_en;
  logic                  illegal;
  logic                  trap;
  logic                  halted;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           alu_func, alu_a_sel, alu_b_sel, w_en, illegal, trap, halted
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           alu_func, alu_a_sel, alu_b_sel, w_en, illegal, trap, halted
  );
endinterface

// File: rtl/ysyx_23060240_idu_pipe.sv
// Pipelined RV32I decode stage between IFU and EXU.
// Accepts one instruction per in_valid/in_ready handshake, decodes it
// combinationally and registers the bundle (out_pc, register indices,
// immediate, ALU controls, w_en, illegal). An accepted ebreak produces a
// one-cycle trap pulse aligned with its bundle and a sticky halted state
// that only rst clears.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : decode-stage bus (slave side), see ysyx_23060240_idu_pipe_if
module ysyx_23060240_idu_pipe #(
  parameter int XLEN       = 32,
  parameter int ALU_FUNC_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_23060240_idu_pipe_if.slave       bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  localparam logic [ALU_FUNC_W-1:0] ALU_ADD   = ALU_FUNC_W'(0);
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB   = ALU_FUNC_W'(1);
  localparam logic [ALU_FUNC_W-1:0] ALU_SLL   = ALU_FUNC_W'(2);
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT   = ALU_FUNC_W'(3);
  localparam logic [ALU_FUNC_W-1:0] ALU_SLTU  = ALU_FUNC_W'(4);
  localparam logic [ALU_FUNC_W-1:0] ALU_XOR   = ALU_FUNC_W'(5);
  localparam logic [ALU_FUNC_W-1:0] ALU_SRL   = ALU_FUNC_W'(6);
  localparam logic [ALU_FUNC_W-1:0] ALU_SRA   = ALU_FUNC_W'(7);
  localparam logic [ALU_FUNC_W-1:0] ALU_OR    = ALU_FUNC_W'(8);
  localparam logic [ALU_FUNC_W-1:0] ALU_AND   = ALU_FUNC_W'(9);
  localparam logic [ALU_FUNC_W-1:0] ALU_PASSB = ALU_FUNC_W'(10);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t state_reg, state_next;

  logic                  out_valid_reg;
  logic                  trap_reg;
  logic [XLEN-1:0]       pc_reg;
  logic [4:0]            rs1_reg, rs2_reg, rd_reg;
  logic [XLEN-1:0]       imm_reg;
  logic [ALU_FUNC_W-1:0] func_reg;
  logic                  a_sel_reg, b_sel_reg, w_en_reg, illegal_reg;

  // Instruction fields
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Handshake
  logic halted;
  logic in_ready;
  logic accept;
  logic is_ebreak;

  assign halted    = (state_reg == ST_HALT);
  assign in_ready  = !halted && (!out_valid_reg || bus.out_ready);
  // flush overrides acceptance: an instruction offered alongside it is dropped
  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign is_ebreak = (inst == INST_EBREAK);

  // Register-register / register-immediate funct3 mapping; alt picks SUB/SRA
  function automatic logic [ALU_FUNC_W-1:0] arith_func(input logic [2:0] f3,
                                                       input logic alt);
    logic [ALU_FUNC_W-1:0] f;
    f = ALU_ADD;
    case (f3)
      3'b000:  f = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f = ALU_SLL;
      3'b010:  f = ALU_SLT;
      3'b011:  f = ALU_SLTU;
      3'b100:  f = ALU_XOR;
      3'b101:  f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

  // Combinational decode
  logic [ALU_FUNC_W-1:0] dec_func;
  logic                  dec_a_sel, dec_b_sel, dec_w_en, dec_illegal;
  logic [31:0]           dec_imm32;

  always_comb begin
    dec_func    = ALU_ADD;
    dec_a_sel   = 1'b0;
    dec_b_sel   = 1'b0;
    dec_w_en    = 1'b0;
    dec_illegal = 1'b0;
    dec_imm32   = 32'd0;
    case (opcode)
      OPC_LUI: begin
        dec_func  = ALU_PASSB;
        dec_b_sel = 1'b1;
        dec_w_en  = 1'b1;
        dec_imm32 = imm_u;
      end
      OPC_AUIPC: begin
        dec_a_sel = 1'b1;
        dec_b_sel = 1'b1;
        dec_w_en  = 1'b1;
        dec_imm32 = imm_u;
      end
      OPC_JAL: begin
        dec_a_sel = 1'b1;
        dec_b_sel = 1'b1;
        dec_w_en  = 1'b1;
        dec_imm32 = imm_j;
      end
      OPC_JALR: begin
        dec_b_sel   = 1'b1;
        dec_w_en    = 1'b1;
        dec_imm32   = imm_i;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_func    = ALU_SUB;
        dec_imm32   = imm_b;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_b_sel   = 1'b1;
        dec_w_en    = 1'b1;
        dec_imm32   = imm_i;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_b_sel   = 1'b1;
        dec_imm32   = imm_s;
        dec_illegal = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec_b_sel = 1'b1;
        dec_w_en  = 1'b1;
        dec_imm32 = imm_i;
        // Only the shift-right form uses funct7 to choose SRA; ADDI has no SUB.
        dec_func  = arith_func(funct3, (funct3 == 3'b101) && (funct7 == 7'h20));
        if (funct3 == 3'b001)
          dec_illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          dec_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        dec_w_en    = 1'b1;
        dec_func    = arith_func(funct3, funct7[5]);
        dec_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_SYSTEM: begin
        dec_imm32   = imm_i;
        dec_illegal = (inst != INST_EBREAK) && (inst != INST_ECALL);
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_w_en = 1'b0;
      dec_func = ALU_ADD;
    end
    if (rd == 5'd0)
      dec_w_en = 1'b0;
  end

  // Halt FSM: leaves HALT only through rst
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:  if (accept && is_ebreak) state_next = ST_HALT;
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  // Output bundle register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      trap_reg      <= 1'b0;
      pc_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      imm_reg       <= '0;
      func_reg      <= '0;
      a_sel_reg     <= 1'b0;
      b_sel_reg     <= 1'b0;
      w_en_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      // accept already excludes flush, so a flushed ebreak never traps
      trap_reg <= accept && is_ebreak;
      if (bus.flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        pc_reg        <= bus.in_pc;
        rs1_reg       <= inst[19:15];
        rs2_reg       <= inst[24:20];
        rd_reg        <= rd;
        imm_reg       <= XLEN'($signed(dec_imm32));
        func_reg      <= dec_func;
        a_sel_reg     <= dec_a_sel;
        b_sel_reg     <= dec_b_sel;
        w_en_reg      <= dec_w_en;
        illegal_reg   <= dec_illegal;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_pc    = pc_reg;
  assign bus.out_rs1   = rs1_reg;
  assign bus.out_rs2   = rs2_reg;
  assign bus.out_rd    = rd_reg;
  assign bus.out_imm   = imm_reg;
  assign bus.alu_func  = func_reg;
  assign bus.alu_a_sel = a_sel_reg;
  assign bus.alu_b_sel = b_sel_reg;
  assign bus.w_en      = w_en_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.trap      = trap_reg;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_ysyx_23060240_idu_pipe.sv
// Directed bench for ysyx_23060240_idu_pipe: a table of decode vectors
// streamed back-to-back, then hand-written stall, flush, ebreak/halt and
// reset sequences.
module tb_ysyx_23060240_idu_pipe;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ysyx_23060240_idu_pipe_if #(.XLEN(32), .ALU_FUNC_W(4)) bus ();

  ysyx_23060240_idu_pipe #(.XLEN(32), .ALU_FUNC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  func;
    logic        a_sel;
    logic        b_sel;
    logic        w_en;
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bundle_now();
    return {bus.alu_func, bus.alu_a_sel, bus.alu_b_sel, bus.w_en, bus.illegal,
            bus.out_imm, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_pc};
  endfunction

  function automatic logic [127:0] bundle_exp(input vec_t v, input logic [31:0] pc);
    logic [31:0] w;
    w = v.inst;
    return {v.func, v.a_sel, v.b_sel, v.w_en, v.ill, v.imm,
            w[11:7], w[19:15], w[24:20], pc};
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0000_0013;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] held;
    errors = 0;
    checks = 0;

    //            inst          func  a  b  wen ill imm
    vecs[0]  = '{32'h00500093, 4'd0, 0, 1, 1, 0, 32'h0000_0005}; // addi x1,x0,5
    vecs[1]  = '{32'h40208133, 4'd1, 0, 0, 1, 0, 32'h0000_0000}; // sub x2,x1,x2
    vecs[2]  = '{32'h000012b7, 4'd10,0, 1, 1, 0, 32'h0000_1000}; // lui x5,1
    vecs[3]  = '{32'h12345197, 4'd0, 1, 1, 1, 0, 32'h1234_5000}; // auipc x3
    vecs[4]  = '{32'h008000ef, 4'd0, 1, 1, 1, 0, 32'h0000_0008}; // jal x1,8
    vecs[5]  = '{32'h00008067, 4'd0, 0, 1, 0, 0, 32'h0000_0000}; // jalr x0,0(x1)
    vecs[6]  = '{32'hfe208ee3, 4'd1, 0, 0, 0, 0, 32'hffff_fffc}; // beq -4
    vecs[7]  = '{32'hff812303, 4'd0, 0, 1, 1, 0, 32'hffff_fff8}; // lw x6,-8(x2)
    vecs[8]  = '{32'h00512623, 4'd0, 0, 1, 0, 0, 32'h0000_000c}; // sw x5,12(x2)
    vecs[9]  = '{32'h4030d393, 4'd7, 0, 1, 1, 0, 32'h0000_0403}; // srai x7,x1,3
    vecs[10] = '{32'h0000007f, 4'd0, 0, 0, 0, 1, 32'h0000_0000}; // bad opcode
    vecs[11] = '{32'h02000033, 4'd0, 0, 0, 0, 1, 32'h0000_0000}; // OP funct7=1
    vecs[12] = '{32'h00100013, 4'd0, 0, 1, 0, 0, 32'h0000_0001}; // addi x0,x0,1
    vecs[13] = '{32'h40109093, 4'd0, 0, 1, 0, 1, 32'h0000_0401}; // slli funct7=0x20
    vecs[14] = '{32'h00000073, 4'd0, 0, 0, 0, 0, 32'h0000_0000}; // ecall
    vecs[15] = '{32'h0020c1b3, 4'd5, 0, 0, 1, 0, 32'h0000_0000}; // xor x3,x1,x2
    vecs[16] = '{32'hfff0b213, 4'd4, 0, 1, 1, 0, 32'hffff_ffff}; // sltiu x4,x1,-1

    do_reset();
    check("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("reset_in_ready",  128'(bus.in_ready),  128'(1'b1));
    check("reset_halted",    128'(bus.halted),    128'(1'b0));
    check("reset_trap",      128'(bus.trap),      128'(1'b0));
    check("reset_bundle",    bundle_now(),        128'(0));

    // Back-to-back stream, out_ready held high: one bundle per cycle
    for (int i = 0; i < NV; i++) begin
      logic [31:0] pc;
      pc = 32'h8000_0000 + 32'(i * 4);
      check($sformatf("stream_in_ready[%0d]", i), 128'(bus.in_ready), 128'(1'b1));
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      bus.in_pc    = pc;
      step();
      check($sformatf("stream_valid[%0d]", i), 128'(bus.out_valid), 128'(1'b1));
      check($sformatf("stream_bundle[%0d]", i), bundle_now(), bundle_exp(vecs[i], pc));
      $display("vec %0d inst=%h func=%0d imm=%h", i, vecs[i].inst, bus.alu_func, bus.out_imm);
    end
    bus.in_valid = 1'b0;
    step();
    check("drain_valid", 128'(bus.out_valid), 128'(1'b0));

    // Stall: hold a bundle for 3 cycles with a new instruction waiting
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h00500093;
    bus.in_pc     = 32'h0000_0100;
    bus.out_ready = 1'b0;
    step();
    held = bundle_exp(vecs[0], 32'h0000_0100);
    bus.in_inst = 32'h40208133;
    bus.in_pc   = 32'h0000_0104;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall_in_ready[%0d]", c), 128'(bus.in_ready), 128'(1'b0));
      check($sformatf("stall_bundle[%0d]", c), {bundle_now()}, held);
      check($sformatf("stall_valid[%0d]", c), 128'(bus.out_valid), 128'(1'b1));
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 128'(bus.in_ready), 128'(1'b1));
    step();
    check("release_bundle", bundle_now(), bundle_exp(vecs[1], 32'h0000_0104));
    check("release_valid", 128'(bus.out_valid), 128'(1'b1));
    bus.in_valid = 1'b0;
    step();
    $display("stall sequence done out_valid=%0b", bus.out_valid);

    // Flush while a bundle is held
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h00500093;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_held_valid", 128'(bus.out_valid), 128'(1'b0));
    $display("flush of held bundle out_valid=%0b", bus.out_valid);

    // Flush in the same cycle an ebreak is offered
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h00100073;
    bus.flush     = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_ebreak_valid",  128'(bus.out_valid), 128'(1'b0));
    check("flush_ebreak_trap",   128'(bus.trap),      128'(1'b0));
    check("flush_ebreak_halted", 128'(bus.halted),    128'(1'b0));
    step();
    check("flush_ebreak_halted2", 128'(bus.halted),   128'(1'b0));
    $display("flush with ebreak trap=%0b halted=%0b", bus.trap, bus.halted);

    // Ebreak accepted with the EXU stalled: trap pulses once, halt sticks
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h00100073;
    bus.in_pc     = 32'h0000_0200;
    bus.out_ready = 1'b0;
    step();
    check("ebreak_valid",  128'(bus.out_valid), 128'(1'b1));
    check("ebreak_trap",   128'(bus.trap),      128'(1'b1));
    check("ebreak_halted", 128'(bus.halted),    128'(1'b1));
    check("ebreak_w_en",   128'(bus.w_en),      128'(1'b0));
    check("ebreak_imm",    128'(bus.out_imm),   128'(32'h1));
    bus.in_inst = 32'h00500093;
    step();
    check("ebreak_trap_off",  128'(bus.trap),      128'(1'b0));
    check("ebreak_hold",      128'(bus.out_valid), 128'(1'b1));
    check("ebreak_in_ready",  128'(bus.in_ready),  128'(1'b0));
    check("ebreak_hold_pc",   128'(bus.out_pc),    128'(32'h0000_0200));
    bus.out_ready = 1'b1;
    step();
    check("halt_drained",     128'(bus.out_valid), 128'(1'b0));
    check("halt_in_ready",    128'(bus.in_ready),  128'(1'b0));
    step();
    check("halt_ignore",      128'(bus.out_valid), 128'(1'b0));
    check("halt_sticky",      128'(bus.halted),    128'(1'b1));
    check("halt_trap_low",    128'(bus.trap),      128'(1'b0));
    $display("ebreak sequence halted=%0b out_valid=%0b", bus.halted, bus.out_valid);

    // Reset clears HALT
    do_reset();
    check("rst_halted",   128'(bus.halted),    128'(1'b0));
    check("rst_in_ready", 128'(bus.in_ready),  128'(1'b1));
    check("rst_valid",    128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h00500093;
    bus.in_pc    = 32'h0000_0300;
    step();
    bus.in_valid = 1'b0;
    check("post_rst_bundle", bundle_now(), bundle_exp(vecs[0], 32'h0000_0300));
    $display("post-reset accept out_valid=%0b", bus.out_valid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_idu_pipe.md
# ysyx_23060240_idu_pipe

Pipelined RV32I decode stage for the NPC core, between the IFU and the EXU. It accepts one instruction per valid/ready handshake and decodes it into ALU controls, operand selects, write enable and immediate. Results are held in an output register. Detection of `ebreak` gives a registered trap pulse and a sticky halt. Illegal encodings are flagged, not trapped.

## Interface
- XLEN, 32: width of pc and immediate datapath.
- ALU_FUNC_W, 4: width of alu_func; must be ≥4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  IFU presents instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard held output (redirect).
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU consumes bundle.
- out_pc  out  XLEN  registered in_pc.
- out_rs1, out_rs2, out_rd  out  5 each  register indices inst[19:15], [24:20], [11:7].
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode; 0 for R-type).
- alu_func  out  ALU_FUNC_W  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- alu_a_sel  out  1  0 = rs1, 1 = pc.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- w_en  out  1  writes rd.
- illegal  out  1  unrecognised encoding.
- trap  out  1  one-cycle pulse: ebreak decoded.
- halted  out  1  sticky after ebreak.

## Operation
- Decode rules:
  - LUI: PASSB, b = imm.
  - AUIPC: ADD, a = pc, b = imm.
  - JAL/JALR: ADD. a = pc for JAL, rs1 for JALR. b = imm.
  - BRANCH: SUB, rs1/rs2, w_en = 0.
  - LOAD/STORE: ADD, rs1 + imm. w_en = 1 for LOAD, 0 for STORE.
  - OP-IMM/OP: alu_func from funct3, with funct7[5] selecting SUB/SRA. b = imm for OP-IMM, rs2 for OP.
  - SYSTEM 0x00100073 (ebreak) and 0x00000073 (ecall): w_en = 0, ADD.
- w_en is forced to 0 when rd == 0.
- illegal = 1 for any other opcode, bad funct3, or bad funct7 (OP funct7 other than 0x00/0x20). Also for OP-IMM shifts with funct7 not 0x00/0x20 (0x20 only for SRAI). When illegal = 1: w_en = 0, alu_func = ADD, other fields decoded as far as possible.
- State machine:
  - RUN → HALT when an ebreak is accepted, i.e. in_valid & in_ready & inst == 0x00100073 & !flush.
  - HALT → RUN only on rst.
- in_ready = !halted & (!out_valid | out_ready).
- Priority per cycle: rst > flush > accept > hold.
  - flush: out_valid ← 0. Any instruction offered this cycle is dropped; no trap, no halt.
  - accept: all out_* fields register from the decode of in_inst/in_pc; out_valid ← 1.
  - consume without accept (out_valid & out_ready & !in_valid): out_valid ← 0.
  - hold (out_valid & !out_ready): every out_* field stable.
- trap = 1 exactly in the cycle following ebreak acceptance, aligned with its out_valid; then 0.
- halted = 1 from that same cycle. The ebreak bundle is still delivered downstream.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Reset values:
  - out_valid = 0, trap = 0, halted = 0, illegal = 0, w_en = 0.
  - alu_func = 0, alu_a_sel = 0, alu_b_sel = 0.
  - out_pc = 0, out_imm = 0, out_rs1/rs2/rd = 0.
- in_ready is combinational from out_valid, out_ready and halted; no combinational path from in_valid.
- Accept simultaneous with consume (full pipe, out_ready = 1) replaces the bundle with no bubble.
- flush while out_valid & !out_ready: bundle lost; out_valid = 0 next cycle.
- rst mid-stream: all state cleared next edge, including HALT.
- Halted: in_valid ignored. The last bundle drains normally on out_ready.

## Test plan
- Reset → out_valid = 0, in_ready = 1, halted = 0. Then `addi x1,x0,5` (0x00500093) → next cycle: alu_func = 0, alu_b_sel = 1, out_imm = 5, w_en = 1, out_rd = 1.
- Back-to-back stream of 0x00500093, 0x40208133 (sub), 0x000012b7 (lui) with out_ready = 1 → three consecutive out_valid cycles with alu_func 0, 1, 10. out_imm of lui = 0x00001000.
- Stall: out_ready = 0 for 3 cycles with a bundle held → in_ready = 0, outputs stable. Release → next instruction accepted the same cycle.
- Ebreak 0x00100073 → trap high exactly one cycle with out_valid, halted = 1. Subsequent in_valid is not accepted until rst; rst returns halted = 0.
- flush in the same cycle ebreak is offered → no trap, halted = 0, out_valid = 0.
- 0x0000007f and 0x02000033 (OP, funct7 = 0x01) → illegal = 1, w_en = 0. `addi x0,x0,1` → w_en = 0, illegal = 0.
